// File: rtl/lif_tdm_scheduler.sv
// Frame scheduler for a time-multiplexed LIF neuron core: accumulates input
// currents per neuron and, on each tick, sweeps one update command per neuron.
module lif_tdm_scheduler #(
    parameter int N_NEURONS = 8,
    parameter int CUR_W     = 8,
    parameter int REFRAC    = 2,
    localparam int ID_W     = $clog2(N_NEURONS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick,
    input  logic                 ev_valid,
    output logic                 ev_ready,
    input  logic [ID_W-1:0]      ev_id,
    input  logic [CUR_W-1:0]     ev_current,
    output logic                 cmd_valid,
    input  logic                 cmd_ready,
    output logic [ID_W-1:0]      cmd_id,
    output logic [CUR_W-1:0]     cmd_current,
    input  logic                 rsp_valid,
    input  logic                 rsp_spike,
    output logic [N_NEURONS-1:0] spike_out,
    output logic                 frame_done,
    output logic                 busy,
    output logic                 overrun
);

    localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
    localparam logic [ID_W-1:0] LAST_ID     = ID_W'(N_NEURONS - 1);
    localparam logic [RW-1:0]   REFRAC_LOAD = RW'(REFRAC);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t               state, state_nxt;
    logic [ID_W-1:0]      k;
    logic [CUR_W-1:0]     pending [N_NEURONS];
    logic [RW-1:0]        refrac  [N_NEURONS];
    logic [N_NEURONS-1:0] fs;

    logic             skip, cmd_accept, rsp_take, advance, last;
    logic             ev_hit_k, ev_fire;
    logic [CUR_W-1:0] ev_base;
    logic [CUR_W:0]   ev_sum;

    always_comb begin
        cmd_valid   = (state == ISSUE) && (refrac[k] == '0);
        cmd_id      = cmd_valid ? k : '0;
        cmd_current = cmd_valid ? pending[k] : '0;
        cmd_accept  = cmd_valid && cmd_ready;
        skip        = (state == ISSUE) && (refrac[k] != '0);
        rsp_take    = (state == WAIT) && rsp_valid;
        advance     = skip || rsp_take;
        last        = (k == LAST_ID);
        busy        = (state != IDLE);
        // An event to the neuron under command sees the cleared accumulator on
        // the accept cycle and is held off while the command is stalled, so the
        // offered cmd_current cannot change under the core.
        ev_hit_k    = cmd_valid && (ev_id == k);
        ev_base     = ev_hit_k ? '0 : pending[ev_id];
        ev_sum      = {1'b0, ev_base} + {1'b0, ev_current};
        ev_ready    = rst_n && !ev_sum[CUR_W] && !(ev_hit_k && !cmd_ready);
        ev_fire     = ev_valid && ev_ready;
    end

    // NOTE: next-state is defaulted to the current state before the case so no
    // path leaves state_nxt unassigned and infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (tick) state_nxt = ISSUE;
            ISSUE: begin
                if (skip)           state_nxt = last ? DONE : ISSUE;
                else if (cmd_ready) state_nxt = WAIT;
            end
            WAIT:  if (rsp_valid) state_nxt = last ? DONE : ISSUE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            k          <= '0;
            fs         <= '0;
            spike_out  <= '0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_nxt;
            frame_done <= (state == DONE);
            if (state == DONE) spike_out <= fs;
            if (tick && (state != IDLE)) overrun <= 1'b1;

            if ((state == IDLE) && tick) begin
                k  <= '0;
                fs <= '0;
            end else if (advance && !last) begin
                k <= k + 1'b1;
            end

            if (skip)          fs[k] <= 1'b0;
            else if (rsp_take) fs[k] <= rsp_spike;
        end
    end

    // NOTE: the per-neuron accumulators and refractory counters must come out
    // of reset cleared, so they are reset flop arrays rather than a RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                pending[i] <= '0;
                refrac[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < N_NEURONS; i++) begin
                if (ev_fire && (ev_id == ID_W'(i)))
                    pending[i] <= ev_sum[CUR_W-1:0];
                else if (cmd_accept && (k == ID_W'(i)))
                    pending[i] <= '0;

                if (skip && (k == ID_W'(i)))
                    refrac[i] <= refrac[i] - 1'b1;
                else if (rsp_take && rsp_spike && (k == ID_W'(i)))
                    refrac[i] <= REFRAC_LOAD;
            end
        end
    end

endmodule

// File: tb/tb_lif_tdm_scheduler.sv
// Self-checking bench for lif_tdm_scheduler: random events, stalls and spikes
// checked against a frame-level model of accumulators and refractory counts.
module tb_lif_tdm_scheduler;

    localparam int N      = 8;
    localparam int CUR_W  = 8;
    localparam int REFRAC = 2;

    logic             clk = 1'b0;
    logic             rst_n, tick, ev_valid, ev_ready;
    logic [2:0]       ev_id;
    logic [CUR_W-1:0] ev_current;
    logic             cmd_valid, cmd_ready;
    logic [2:0]       cmd_id;
    logic [CUR_W-1:0] cmd_current;
    logic             rsp_valid, rsp_spike;
    logic [N-1:0]     spike_out;
    logic             frame_done, busy, overrun;

    int errors = 0;
    int checks = 0;
    int m_pending [N];
    int m_refrac  [N];

    lif_tdm_scheduler #(.N_NEURONS(N), .CUR_W(CUR_W), .REFRAC(REFRAC)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_id(ev_id), .ev_current(ev_current),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id), .cmd_current(cmd_current),
        .rsp_valid(rsp_valid), .rsp_spike(rsp_spike),
        .spike_out(spike_out), .frame_done(frame_done), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #500_000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    task automatic model_clear();
        for (int n = 0; n < N; n++) begin
            m_pending[n] = 0;
            m_refrac[n]  = 0;
        end
    endtask

    // Offer one event; a rejected one is held for 'hold' more cycles, then withdrawn.
    task automatic send_event(input int id, input int cur, input int hold);
        logic exp_rdy;
        @(negedge clk);
        ev_valid = 1'b1; ev_id = 3'(id); ev_current = CUR_W'(cur);
        #1;
        exp_rdy = (m_pending[id] + cur <= 255);
        checks++;
        if (ev_ready !== exp_rdy)
            $display("FAIL ev_ready id=%0d cur=%0d: got %b expected %b", id, cur, ev_ready, exp_rdy);
        if (exp_rdy) begin
            m_pending[id] += cur;
        end else begin
            repeat (hold) begin
                @(negedge clk); #1;
                checks++;
                if (ev_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL ev_ready_held id=%0d: got %b expected 0", id, ev_ready);
                end
            end
        end
        if (ev_ready !== exp_rdy) errors++;
        @(negedge clk);
        ev_valid = 1'b0;
    endtask

    // One full frame acting as the core. race_id<0 disables the same-cycle
    // event; ovr_cycle=0 disables the tick-while-busy injection.
    task automatic run_frame(input logic [N-1:0] spike_mask, input int max_stall, input bit noise,
                             input int race_id, input int race_val, input int ovr_cycle);
        int exp_id [N];
        int exp_cur [N];
        int n_exp, n_skip, issued, stalls, cyc, stall_left, rsp_left, rsp_id, exp_lat;
        bit in_cmd, waiting, done_seen, busy_bad, race_done;
        logic [N-1:0] exp_spk;

        n_exp = 0; n_skip = 0; exp_spk = '0;
        for (int n = 0; n < N; n++) begin
            if (m_refrac[n] != 0) begin
                m_refrac[n]--;
                n_skip++;
            end else begin
                exp_id[n_exp]  = n;
                exp_cur[n_exp] = m_pending[n];
                n_exp++;
                m_pending[n] = 0;
                if (spike_mask[n]) begin
                    m_refrac[n] = REFRAC;
                    exp_spk[n]  = 1'b1;
                end
            end
        end

        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        cyc = 1; issued = 0; stalls = 0; stall_left = 0; rsp_left = 0; rsp_id = 0;
        in_cmd = 0; waiting = 0; done_seen = 0; busy_bad = 0; race_done = 0;
        while (cyc < 400) begin
            cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_spike = 1'b0; ev_valid = 1'b0;
            tick = (cyc == ovr_cycle);
            if (frame_done === 1'b1) begin
                done_seen = 1;
                break;
            end
            if (busy !== 1'b1) busy_bad = 1;
            if (waiting) begin
                if (rsp_left == 0) begin
                    rsp_valid = 1'b1;
                    rsp_spike = spike_mask[rsp_id];
                    waiting   = 0;
                end else begin
                    rsp_left--;
                    stalls++;
                end
            end else begin
                if (noise && ($urandom_range(0, 3) == 0)) begin
                    rsp_valid = 1'b1;
                    rsp_spike = 1'b1;
                end
                if (cmd_valid === 1'b1) begin
                    checks++;
                    if (issued >= n_exp) begin
                        errors++;
                        $display("FAIL cmd_extra: got id=%0d expected no further command", cmd_id);
                    end else if (cmd_id !== 3'(exp_id[issued]) || cmd_current !== CUR_W'(exp_cur[issued])) begin
                        errors++;
                        $display("FAIL cmd_payload: got id=%0d cur=%0d expected id=%0d cur=%0d",
                                 cmd_id, cmd_current, exp_id[issued], exp_cur[issued]);
                    end
                    if (!in_cmd) begin
                        in_cmd = 1;
                        stall_left = $urandom_range(0, max_stall);
                    end
                    if (stall_left == 0) begin
                        cmd_ready = 1'b1;
                        in_cmd    = 0;
                        waiting   = 1;
                        rsp_left  = $urandom_range(0, max_stall);
                        rsp_id    = int'(cmd_id);
                        issued++;
                        if (race_id >= 0 && int'(cmd_id) == race_id) begin
                            ev_valid = 1'b1; ev_id = 3'(race_id); ev_current = CUR_W'(race_val);
                            #1;
                            checks++;
                            if (ev_ready !== 1'b1) begin
                                errors++;
                                $display("FAIL race_ev_ready: got %b expected 1", ev_ready);
                            end
                            race_done = 1;
                        end
                    end else begin
                        stall_left--;
                        stalls++;
                    end
                end
            end
            @(negedge clk);
            cyc++;
        end
        tick = 1'b0; cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_spike = 1'b0; ev_valid = 1'b0;

        checks++;
        if (!done_seen) begin
            errors++;
            $display("FAIL frame_timeout: no frame_done within %0d cycles", cyc);
        end else begin
            exp_lat = 2 + 2 * n_exp + n_skip + stalls;
            checks++;
            if (cyc != exp_lat) begin
                errors++;
                $display("FAIL frame_latency: got %0d expected %0d", cyc, exp_lat);
            end
            checks++;
            if (spike_out !== exp_spk) begin
                errors++;
                $display("FAIL spike_out: got %h expected %h", spike_out, exp_spk);
            end
            checks++;
            if (busy !== 1'b0 || busy_bad) begin
                errors++;
                $display("FAIL busy_window: got busy=%b gap=%0d expected busy=0 gap=0", busy, busy_bad);
            end
        end
        checks++;
        if (issued != n_exp) begin
            errors++;
            $display("FAIL cmd_count: got %0d expected %0d", issued, n_exp);
        end
        if (race_id >= 0) begin
            checks++;
            if (!race_done) begin
                errors++;
                $display("FAIL race_missed: got 0 expected 1 race event for id %0d", race_id);
            end
            m_pending[race_id] = race_val;
        end
        @(negedge clk);
        checks++;
        if (frame_done !== 1'b0) begin
            errors++;
            $display("FAIL frame_done_width: got %b expected 0", frame_done);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ev_valid = 1'b1; ev_id = 3'd1; ev_current = 8'd1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({cmd_valid, cmd_id, cmd_current} !== 12'd0) begin
            errors++;
            $display("FAIL reset_cmd: got %h expected 000", {cmd_valid, cmd_id, cmd_current});
        end
        checks++;
        if ({spike_out, frame_done, busy, overrun} !== 11'd0) begin
            errors++;
            $display("FAIL reset_status: got %h expected 000", {spike_out, frame_done, busy, overrun});
        end
        checks++;
        if (ev_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ev_ready: got %b expected 0", ev_ready);
        end
        ev_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic test_accumulation();
        send_event(3, 40, 0);
        send_event(3, 50, 0);
        send_event(5, 255, 0);
        run_frame(8'h00, 0, 0, -1, 0, 0);
        run_frame(8'h00, 0, 0, -1, 0, 0);
    endtask

    task automatic test_backpressure();
        send_event(2, 200, 0);
        send_event(2, 55, 0);
        send_event(2, 100, 3);
        send_event(2, 1, 1);
        run_frame(8'h00, 0, 0, -1, 0, 0);
        send_event(2, 100, 0);
        run_frame(8'h00, 0, 0, -1, 0, 0);
    endtask

    task automatic test_refractory();
        send_event(4, 30, 0);
        run_frame(8'h10, 0, 0, -1, 0, 0);
        send_event(4, 20, 0);
        run_frame(8'h00, 0, 1, -1, 0, 0);
        send_event(4, 5, 0);
        run_frame(8'h00, 0, 1, -1, 0, 0);
        run_frame(8'h00, 0, 0, -1, 0, 0);
    endtask

    task automatic test_stalls();
        for (int f = 0; f < 6; f++) begin
            for (int e = 0; e < 3; e++)
                send_event(int'($urandom_range(0, N - 1)), int'($urandom_range(1, 255)), 1);
            run_frame(N'($urandom), 3, 1, -1, 0, 0);
        end
    endtask

    task automatic test_overrun_race();
        run_frame(8'h00, 1, 0, -1, 0, 0);
        run_frame(8'h00, 1, 0, -1, 0, 0);
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_initial: got %b expected 0", overrun);
        end
        send_event(6, 9, 0);
        run_frame(8'h00, 1, 0, 6, 77, 5);
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set: got %b expected 1", overrun);
        end
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (frame_done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL overrun_extra_frame: got busy=%b frame_done=%b expected 0 0", busy, frame_done);
                break;
            end
        end
        checks++;
        run_frame(8'h00, 0, 0, -1, 0, 0);
    endtask

    task automatic test_reset_midframe();
        bit found, waiting;
        run_frame(8'h01, 0, 0, -1, 0, 0);
        send_event(1, 10, 0);
        send_event(3, 20, 0);
        send_event(7, 5, 0);
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        found = 0; waiting = 0;
        for (int c = 0; c < 60 && !found; c++) begin
            cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_spike = 1'b0;
            if (waiting) begin
                rsp_valid = 1'b1;
                waiting   = 0;
            end else if (cmd_valid === 1'b1) begin
                cmd_ready = 1'b1;
                waiting   = 1;
                if (cmd_id == 3'd3) found = 1;
            end
            @(negedge clk);
        end
        cmd_ready = 1'b0;
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL midframe_reach: got no command for id 3 expected one");
        end
        rsp_valid = 1'b1; rsp_spike = 1'b1;
        ev_valid = 1'b1; ev_id = 3'd0; ev_current = 8'd1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({cmd_valid, cmd_id, cmd_current} !== 12'd0) begin
            errors++;
            $display("FAIL midreset_cmd: got %h expected 000", {cmd_valid, cmd_id, cmd_current});
        end
        checks++;
        if ({spike_out, frame_done, busy, overrun} !== 11'd0) begin
            errors++;
            $display("FAIL midreset_status: got %h expected 000", {spike_out, frame_done, busy, overrun});
        end
        checks++;
        if (ev_ready !== 1'b0) begin
            errors++;
            $display("FAIL midreset_ev_ready: got %b expected 0", ev_ready);
        end
        @(negedge clk);
        rsp_valid = 1'b0; rsp_spike = 1'b0; ev_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        run_frame(8'h00, 0, 0, -1, 0, 0);
    endtask

    initial begin
        rst_n = 1'b0; tick = 1'b0; ev_valid = 1'b0; ev_id = '0; ev_current = '0;
        cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_spike = 1'b0;
        model_clear();
        test_reset();
        test_accumulation();
        test_backpressure();
        test_refractory();
        test_stalls();
        test_overrun_race();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lif_tdm_scheduler.md
# lif_tdm_scheduler

Frame scheduler for the time-multiplexed LIF neuron core. It accepts input-current events for 8 neurons through a valid/ready port and accumulates them per neuron. On each frame tick it sweeps neurons 0..7 in order, issuing one update command per neuron to the shared LIF core and collecting that neuron's spike result. It also enforces per-neuron refractory periods. It sits between the stimulus/event fabric and the single shared neuron datapath, and publishes a per-frame spike vector.

## Interface
- N_NEURONS, 8: neuron slots swept per frame (ID width 3).
- CUR_W, 8: current and pending-accumulator width.
- REFRAC, 2: frames a neuron is skipped after it spikes (0 = no refractory period).
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- tick  in  1  frame-start pulse.
- ev_valid  in  1  input event valid.
- ev_ready  out  1  event accepted this cycle.
- ev_id  in  3  target neuron.
- ev_current  in  CUR_W  current to add.
- cmd_valid  out  1  update command to core valid.
- cmd_ready  in  1  core accepts the command.
- cmd_id  out  3  neuron being updated.
- cmd_current  out  CUR_W  accumulated current for that neuron.
- rsp_valid  in  1  core result valid.
- rsp_spike  in  1  neuron crossed threshold.
- spike_out  out  N_NEURONS  spike vector of the last completed frame.
- frame_done  out  1  one-cycle pulse when spike_out updates.
- busy  out  1  frame sweep in progress.
- overrun  out  1  sticky: a tick arrived while busy.

## Operation
- Per-neuron state:
  - pending[k], CUR_W bits.
  - refrac[k], counter of width clog2(REFRAC+1).
  - frame spike bit fs[k].
- Event accumulation:
  - ev_ready is combinational: 1 when pending[ev_id] + ev_current ≤ 2^CUR_W−1, else 0. The sum is computed at CUR_W+1 bits.
  - On ev_valid && ev_ready: pending[ev_id] <= pending[ev_id] + ev_current.
  - A rejected event must be held by the source. It is never dropped or saturated internally.
- State machine states: IDLE, ISSUE, WAIT, DONE. Current neuron index k (3 bits).
  - IDLE: busy=0. On tick: k<=0, clear fs, go to ISSUE.
  - ISSUE, refrac[k]≠0: decrement refrac[k]; cmd_valid stays 0; pending[k] is retained; fs[k]=0. Advance to the next neuron (ISSUE with k+1), or go to DONE if k=7.
  - ISSUE, refrac[k]=0: cmd_valid=1, cmd_id=k, cmd_current=pending[k].
    - Hold the command until cmd_ready.
    - On the accept cycle: pending[k]<=0, go to WAIT.
  - WAIT: on rsp_valid, fs[k]<=rsp_spike. If rsp_spike, refrac[k]<=REFRAC. Then advance as above.
  - DONE: spike_out<=fs, frame_done<=1, go to IDLE.
- Same-cycle event to neuron k on its accept cycle: the new pending[k] equals ev_current, so the event is not lost. ev_ready is evaluated against the value 0 in that cycle.
- Command handshake: cmd_id and cmd_current stay stable while cmd_valid=1 and cmd_ready=0. cmd_valid deasserts in the cycle after acceptance.
- rsp_valid outside WAIT is ignored. Only one command is ever outstanding.
- A tick in any state other than IDLE is dropped and sets overrun. overrun clears only on reset.
- Reset mid-frame:
  - State returns to IDLE.
  - pending, refrac, fs, spike_out and overrun are cleared.
  - Any in-flight core response is discarded.

## Timing
- Reset values:
  - cmd_valid=0, cmd_id=0, cmd_current=0.
  - spike_out=0, frame_done=0, busy=0, overrun=0.
  - ev_ready=0 while rst_n is low.
- busy=1 from the cycle after a tick is accepted through the DONE cycle inclusive.
- Zero-wait core (cmd_ready=1, rsp_valid in the cycle after acceptance): 2 cycles per active neuron, 1 cycle per refractory neuron.
- With tick sampled at edge 0:
  - ISSUE for neuron 0 is at cycle 1.
  - With all 8 neurons active, DONE is at cycle 17; frame_done is high in cycle 18 and spike_out is valid from cycle 18.
- Each cycle of cmd_ready=0, or of a rsp_valid delay, adds one cycle.
- frame_done is exactly 1 cycle wide. A tick in the frame_done cycle is accepted, because the state is already IDLE.

## Test plan
- Accumulation: events (id3,40), (id3,50), (id5,255), then tick. Required: cmd_current=90 for id3, 255 for id5, 0 for all other neurons; pending is 0 afterwards.
- Backpressure: pending[2]=200, then ev (id2,100). Required: ev_ready=0 while held. After a tick drains id2, ev_ready=1 and the new pending[2]=100.
- Refractory: REFRAC=2, and the core spikes neuron 4 in frame 1. Required: spike_out=0x10 in frame 1; no command for id4 in frames 2–3; id4 is issued again in frame 4 with its retained pending current.
- Handshake stalls: random cmd_ready/rsp_valid delays of 0–3 cycles. Required: cmd payload stable while stalled; the frame latency increases by the total stall cycles.
- Overrun and same-cycle race: a tick while busy → overrun=1 and no extra frame. An event to id k in the cycle id k's command is accepted → the event appears in the next frame's cmd_current.
- Reset mid-frame: assert rst_n low during WAIT for neuron 3. Required: all outputs at reset values; the next tick starts a fresh frame at neuron 0 with pending=0.
